// File: rtl/md5_core_if.sv
// Request/response bundle for the single-block MD5 core.
interface md5_core_if;
   logic [511:0] msg_padded;
   logic         msg_in_valid;
   logic [127:0] msg_output;
   logic         msg_out_valid;
   logic         ready;

   // Requester side: presents blocks, observes digest and status.
   modport master (
      output msg_padded,
      output msg_in_valid,
      input  msg_output,
      input  msg_out_valid,
      input  ready
   );

   // Core side.
   modport slave (
      input  msg_padded,
      input  msg_in_valid,
      output msg_output,
      output msg_out_valid,
      output ready
   );
endinterface

// File: rtl/md5_core.sv
// Single-block MD5 compression: two steps per cycle, digest 32 cycles after accept.
module md5_core (
   input logic       clk,
   input logic       rst,
   md5_core_if.slave md5_bus
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam logic [31:0] IvA = 32'h67452301;
   localparam logic [31:0] IvB = 32'hefcdab89;
   localparam logic [31:0] IvC = 32'h98badcfe;
   localparam logic [31:0] IvD = 32'h10325476;

   // Per-step additive constants.
   function automatic logic [31:0] k_const(input logic [5:0] i);
      logic [31:0] k;
      k = '0;
      case (i)
         6'd0:  k = 32'hd76aa478;  6'd1:  k = 32'he8c7b756;  6'd2:  k = 32'h242070db;
         6'd3:  k = 32'hc1bdceee;  6'd4:  k = 32'hf57c0faf;  6'd5:  k = 32'h4787c62a;
         6'd6:  k = 32'ha8304613;  6'd7:  k = 32'hfd469501;  6'd8:  k = 32'h698098d8;
         6'd9:  k = 32'h8b44f7af;  6'd10: k = 32'hffff5bb1;  6'd11: k = 32'h895cd7be;
         6'd12: k = 32'h6b901122;  6'd13: k = 32'hfd987193;  6'd14: k = 32'ha679438e;
         6'd15: k = 32'h49b40821;  6'd16: k = 32'hf61e2562;  6'd17: k = 32'hc040b340;
         6'd18: k = 32'h265e5a51;  6'd19: k = 32'he9b6c7aa;  6'd20: k = 32'hd62f105d;
         6'd21: k = 32'h02441453;  6'd22: k = 32'hd8a1e681;  6'd23: k = 32'he7d3fbc8;
         6'd24: k = 32'h21e1cde6;  6'd25: k = 32'hc33707d6;  6'd26: k = 32'hf4d50d87;
         6'd27: k = 32'h455a14ed;  6'd28: k = 32'ha9e3e905;  6'd29: k = 32'hfcefa3f8;
         6'd30: k = 32'h676f02d9;  6'd31: k = 32'h8d2a4c8a;  6'd32: k = 32'hfffa3942;
         6'd33: k = 32'h8771f681;  6'd34: k = 32'h6d9d6122;  6'd35: k = 32'hfde5380c;
         6'd36: k = 32'ha4beea44;  6'd37: k = 32'h4bdecfa9;  6'd38: k = 32'hf6bb4b60;
         6'd39: k = 32'hbebfbc70;  6'd40: k = 32'h289b7ec6;  6'd41: k = 32'heaa127fa;
         6'd42: k = 32'hd4ef3085;  6'd43: k = 32'h04881d05;  6'd44: k = 32'hd9d4d039;
         6'd45: k = 32'he6db99e5;  6'd46: k = 32'h1fa27cf8;  6'd47: k = 32'hc4ac5665;
         6'd48: k = 32'hf4292244;  6'd49: k = 32'h432aff97;  6'd50: k = 32'hab9423a7;
         6'd51: k = 32'hfc93a039;  6'd52: k = 32'h655b59c3;  6'd53: k = 32'h8f0ccc92;
         6'd54: k = 32'hffeff47d;  6'd55: k = 32'h85845dd1;  6'd56: k = 32'h6fa87e4f;
         6'd57: k = 32'hfe2ce6e0;  6'd58: k = 32'ha3014314;  6'd59: k = 32'h4e0811a1;
         6'd60: k = 32'hf7537e82;  6'd61: k = 32'hbd3af235;  6'd62: k = 32'h2ad7d2bb;
         6'd63: k = 32'heb86d391;
      endcase
      return k;
   endfunction

   // Rotate amounts: one row of four per round, selected by step index mod 4.
   function automatic logic [4:0] shift_amt(input logic [5:0] i);
      logic [4:0] s;
      s = '0;
      case ({i[5:4], i[1:0]})
         4'h0: s = 5'd7;  4'h1: s = 5'd12; 4'h2: s = 5'd17; 4'h3: s = 5'd22;
         4'h4: s = 5'd5;  4'h5: s = 5'd9;  4'h6: s = 5'd14; 4'h7: s = 5'd20;
         4'h8: s = 5'd4;  4'h9: s = 5'd11; 4'ha: s = 5'd16; 4'hb: s = 5'd23;
         4'hc: s = 5'd6;  4'hd: s = 5'd10; 4'he: s = 5'd15; 4'hf: s = 5'd21;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // One MD5 step; returns the rotated working set {a', b', c', d'}.
   function automatic logic [127:0] md5_step(input logic [5:0] i, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c,
                                             input logic [31:0] d, input logic [511:0] blk);
      logic [31:0]  f;
      logic [31:0]  m;
      logic [31:0]  sum;
      logic [5:0]   t;
      logic [3:0]   g;
      logic [511:0] sh;
      logic [63:0]  rot;
      f = '0;
      t = '0;
      case (i[5:4])
         2'd0: begin f = (b & c) | (~b & d);  t = i;                  end
         2'd1: begin f = (b & d) | (c & ~d);  t = i * 6'd5 + 6'd1;    end
         2'd2: begin f = b ^ c ^ d;           t = i * 6'd3 + 6'd5;    end
         2'd3: begin f = c ^ (b | ~d);        t = i * 6'd7;           end
      endcase
      g = t[3:0];
      // Word g sits at byte offset 4g from the MSB end, stored little-endian.
      sh = blk << {g, 5'b0};
      m = bswap(sh[511:480]);
      sum = a + f + k_const(i) + m;
      rot = {sum, sum} << shift_amt(i);
      return {d, b + rot[63:32], b, c};
   endfunction

   state_e       state_q;
   logic         ready_q;
   logic         valid_q;
   logic [4:0]   cnt_q;
   logic [511:0] blk_q;
   logic [31:0]  a_q, b_q, c_q, d_q;
   logic [127:0] digest_q;

   logic [127:0] step0, step1, digest_d;

   // Two chained steps per cycle and the digest that would result after the final pair.
   always_comb begin
      step0 = md5_step({cnt_q, 1'b0}, a_q, b_q, c_q, d_q, blk_q);
      step1 = md5_step({cnt_q, 1'b1}, step0[127:96], step0[95:64], step0[63:32],
                       step0[31:0], blk_q);
      digest_d = {bswap(IvA + step1[127:96]), bswap(IvB + step1[95:64]),
                  bswap(IvC + step1[63:32]), bswap(IvD + step1[31:0])};
   end

   // Control FSM with registered status/digest outputs and working registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
         blk_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         d_q      <= '0;
         digest_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (md5_bus.msg_in_valid) begin
                  blk_q   <= md5_bus.msg_padded;
                  a_q     <= IvA;
                  b_q     <= IvB;
                  c_q     <= IvC;
                  d_q     <= IvD;
                  valid_q <= 1'b0;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  state_q <= StRun;
               end
            end
            StRun: begin
               a_q   <= step1[127:96];
               b_q   <= step1[95:64];
               c_q   <= step1[63:32];
               d_q   <= step1[31:0];
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  digest_q <= digest_d;
                  valid_q  <= 1'b1;
                  ready_q  <= 1'b1;
                  state_q  <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign md5_bus.msg_output    = digest_q;
   assign md5_bus.msg_out_valid = valid_q;
   assign md5_bus.ready         = ready_q;

endmodule

// File: tb/tb_md5_core.sv
// Self-checking bench for md5_core: known vectors, handshake timing, reset abort, random blocks.
module tb_md5_core;

   logic clk;
   logic rst;
   md5_core_if bus ();

   md5_core u_dut (
      .clk     (clk),
      .rst     (rst),
      .md5_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [127:0] DigEmpty = 128'hd41d8cd98f00b204e9800998ecf8427e;
   localparam logic [127:0] DigAbc   = 128'h900150983cd24fb0d6963f7d28e17f72;

   logic [31:0]  kt [64];
   logic [511:0] blk_empty;
   logic [511:0] blk_abc;

   // Reference: textbook RFC 1321 loop over 64 steps with sine-derived constants.
   function automatic logic [31:0] rotl32(input logic [31:0] x, input int s);
      return (x << s) | (x >> (32 - s));
   endfunction

   function automatic logic [127:0] md5_ref(input logic [511:0] blk);
      int          shr [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20},
                                  '{4, 11, 16, 23}, '{6, 10, 15, 21}};
      logic [31:0] m [16];
      logic [31:0] h [4];
      logic [31:0] a, b, c, d, f, tmp;
      logic [7:0]  byt;
      logic [127:0] out;
      int          g;
      for (int j = 0; j < 16; j++) m[j] = '0;
      for (int k = 0; k < 64; k++) begin
         byt = blk[511 - 8 * k -: 8];
         m[k / 4] = m[k / 4] | (32'(byt) << (8 * (k % 4)));
      end
      h[0] = 32'h67452301; h[1] = 32'hefcdab89; h[2] = 32'h98badcfe; h[3] = 32'h10325476;
      a = h[0]; b = h[1]; c = h[2]; d = h[3];
      for (int i = 0; i < 64; i++) begin
         case (i / 16)
            0:       begin f = (b & c) | (~b & d); g = i;                end
            1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
         endcase
         tmp = d;
         d = c;
         c = b;
         b = b + rotl32(a + f + kt[i] + m[g], shr[i / 16][i % 4]);
         a = tmp;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d;
      out = '0;
      for (int w = 0; w < 4; w++)
         for (int n = 0; n < 4; n++)
            out[127 - 8 * (4 * w + n) -: 8] = 8'(h[w] >> (8 * n));
      return out;
   endfunction

   // Present a block with a single-cycle request; returns just after the accepting edge.
   task automatic pulse_request(input logic [511:0] blk);
      bus.msg_padded   = blk;
      bus.msg_in_valid = 1'b1;
      @(posedge clk); #1;
      bus.msg_in_valid = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if (bus.ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", bus.ready);
      else n_pass++;
      n_checks++;
      if (bus.msg_out_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", bus.msg_out_valid);
      else n_pass++;
      n_checks++;
      if (bus.msg_output !== 128'h0) $display("FAIL reset_output got=%h want=0", bus.msg_output);
      else n_pass++;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (bus.ready !== 1'b1 || bus.msg_out_valid !== 1'b0)
         $display("FAIL reset_idle got ready=%b valid=%b want ready=1 valid=0",
                  bus.ready, bus.msg_out_valid);
      else n_pass++;
   endtask

   task automatic test_known(input string name, input logic [511:0] blk, input logic [127:0] dig);
      int lat = 0;
      pulse_request(blk);
      n_checks++;
      if (bus.ready !== 1'b0) $display("FAIL %s_busy got ready=%b want=0", name, bus.ready);
      else n_pass++;
      while (bus.msg_out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      n_checks++;
      if (lat !== 32) $display("FAIL %s_latency got=%0d want=32", name, lat);
      else n_pass++;
      n_checks++;
      if (bus.msg_output !== dig) $display("FAIL %s_digest got=%h want=%h", name, bus.msg_output, dig);
      else n_pass++;
      n_checks++;
      if (bus.ready !== 1'b1) $display("FAIL %s_ready_done got=%b want=1", name, bus.ready);
      else n_pass++;
   endtask

   task automatic test_ignore_during_run();
      int lat = 0;
      pulse_request(blk_abc);
      repeat (5) begin @(posedge clk); #1; lat++; end
      bus.msg_padded   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom};
      bus.msg_in_valid = 1'b1;
      repeat (2) begin @(posedge clk); #1; lat++; end
      bus.msg_in_valid = 1'b0;
      while (bus.msg_out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      n_checks++;
      if (lat !== 32) $display("FAIL ignore_latency got=%0d want=32", lat);
      else n_pass++;
      n_checks++;
      if (bus.msg_output !== DigAbc) $display("FAIL ignore_digest got=%h want=%h", bus.msg_output, DigAbc);
      else n_pass++;
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (bus.ready !== 1'b1 || bus.msg_out_valid !== 1'b1 || bus.msg_output !== DigAbc)
         $display("FAIL ignore_hold got ready=%b valid=%b out=%h want ready=1 valid=1 out=%h",
                  bus.ready, bus.msg_out_valid, bus.msg_output, DigAbc);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic exp_done;
      int   waited = 0;
      bus.msg_padded   = blk_abc;
      bus.msg_in_valid = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk); #1;
         // A run occupies 32 edges after its accept edge; the next accept follows one edge later.
         exp_done = ((k - 1) % 33) == 32;
         n_checks++;
         if (bus.ready !== exp_done) $display("FAIL b2b_ready cyc=%0d got=%b want=%b", k, bus.ready, exp_done);
         else n_pass++;
         n_checks++;
         if (bus.msg_out_valid !== exp_done)
            $display("FAIL b2b_valid cyc=%0d got=%b want=%b", k, bus.msg_out_valid, exp_done);
         else n_pass++;
         if (exp_done) begin
            n_checks++;
            if (bus.msg_output !== DigAbc)
               $display("FAIL b2b_digest cyc=%0d got=%h want=%h", k, bus.msg_output, DigAbc);
            else n_pass++;
         end
      end
      bus.msg_in_valid = 1'b0;
      while (bus.ready !== 1'b1 && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      n_checks++;
      if (bus.ready !== 1'b1) $display("FAIL b2b_drain got ready=%b want=1", bus.ready);
      else n_pass++;
   endtask

   task automatic test_reset_during_run();
      pulse_request(blk_abc);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.ready !== 1'b1 || bus.msg_out_valid !== 1'b0 || bus.msg_output !== 128'h0)
         $display("FAIL abort_state got ready=%b valid=%b out=%h want ready=1 valid=0 out=0",
                  bus.ready, bus.msg_out_valid, bus.msg_output);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      n_checks++;
      if (bus.msg_out_valid !== 1'b0 || bus.ready !== 1'b1)
         $display("FAIL abort_no_digest got valid=%b ready=%b want valid=0 ready=1",
                  bus.msg_out_valid, bus.ready);
      else n_pass++;
      test_known("after_abort", blk_empty, DigEmpty);
   endtask

   task automatic test_random();
      logic [511:0] blk;
      logic [127:0] exp;
      for (int r = 0; r < 30; r++) begin
         for (int w = 0; w < 16; w++) blk[32 * w +: 32] = $urandom;
         exp = md5_ref(blk);
         pulse_request(blk);
         repeat (49) @(posedge clk);
         #1;
         n_checks++;
         if (bus.msg_out_valid !== 1'b1 || bus.msg_output !== exp)
            $display("FAIL random_%0d got valid=%b out=%h want valid=1 out=%h",
                     r, bus.msg_out_valid, bus.msg_output, exp);
         else n_pass++;
      end
   endtask

   initial begin
      real v;
      rst              = 1'b0;
      bus.msg_in_valid = 1'b0;
      bus.msg_padded   = '0;
      for (int i = 0; i < 64; i++) begin
         v = $sin(real'(i + 1));
         if (v < 0.0) v = -v;
         kt[i] = 32'(longint'($floor(v * 4294967296.0)));
      end
      blk_empty = '0;
      blk_empty[511:504] = 8'h80;
      blk_abc = '0;
      blk_abc[511:480] = 32'h61626380;
      blk_abc[63:56]   = 8'h18;

      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_known("empty", blk_empty, DigEmpty);
      test_known("abc", blk_abc, DigAbc);
      test_ignore_during_run();
      test_back_to_back();
      test_reset_during_run();
      test_random();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/md5_core.md
MD5_CORE -- requirements
Module: md5_core

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 msg_padded  input  512  one pre-padded MD5 block; [511:504] is stream byte 0, [7:0] is stream byte 63.
REQ-005 msg_in_valid  input  1  request to hash msg_padded.
REQ-006 msg_output  output  128  digest; [127:120] is digest byte 0, so the hex value equals the standard MD5 hex string.
REQ-007 msg_out_valid  output  1  msg_output holds a completed digest.
REQ-008 ready  output  1  block is idle and will accept msg_in_valid.

Function
REQ-009 The block SHALL compute the single-block MD5 digest of msg_padded (RFC 1321) from IV A=67452301, B=efcdab89, C=98badcfe, D=10325476; no padding or multi-block chaining inside the block.
REQ-010 Message word M[j] (j=0..15) SHALL be stream bytes 4j..4j+3 assembled little-endian (byte 4j is the least significant byte).
REQ-011 Steps i=0..63 SHALL use the standard F/G/H/I functions, K[i]=floor(|sin(i+1)|*2^32), the standard shift table, and the standard word index g. All additions are modulo 2^32.
REQ-012 The final digest SHALL be (A+a, B+b, C+c, D+d), each word serialized little-endian into msg_output from byte 0 at the MSB end.
REQ-013 The FSM SHALL have state IDLE (ready=1) and state RUN (ready=0).
REQ-014 In IDLE with msg_in_valid=1 at a rising edge, the block SHALL:
- register msg_padded;
- load a..d with the IV;
- clear msg_out_valid;
- clear the round counter;
- enter RUN.
REQ-015 In RUN the block SHALL perform two MD5 steps per cycle, with a 5-bit counter 0..31.
REQ-016 On the edge that completes counter value 31, the block SHALL:
- register msg_output;
- set msg_out_valid=1;
- return to IDLE.
- Latency: the digest and msg_out_valid are visible 32 cycles after the accepting edge.
REQ-017 msg_in_valid and msg_padded SHALL be ignored while in RUN; the registered copy is used throughout.
REQ-018 msg_output and msg_out_valid SHALL hold until the next message is accepted.
REQ-019 If msg_in_valid is held high, a new message SHALL be accepted on the first edge back in IDLE (back-to-back operation). At that edge msg_out_valid SHALL clear.

Reset
REQ-020 While rst=0 (asynchronously): state=IDLE, ready=1, msg_out_valid=0, msg_output=0, counter=0, working registers=0.
REQ-021 Reset asserted during RUN SHALL abort the computation with no digest output. After release, the block SHALL accept a new message normally.

Verification
REQ-022 Empty message: msg_padded=0x80 followed by 63 zero bytes, one-cycle msg_in_valid -> after 32 cycles msg_out_valid=1, msg_output=d41d8cd98f00b204e9800998ecf8427e, ready=1.
REQ-023 "abc": bytes 61 62 63 80, zeros, byte 56=0x18, bytes 57..63=0 -> msg_output=900150983cd24fb0d6963f7d28e17f72.
REQ-024 Change msg_padded and pulse msg_in_valid during RUN -> the "abc" digest is still produced, with no extra run started.
REQ-025 Hold msg_in_valid=1 with a constant "abc" block for 80 cycles -> ready low 32 cycles, high 1 cycle, low again. msg_out_valid is high for exactly 1 cycle per completion.
REQ-026 Assert rst at cycle 10 of RUN -> immediately ready=1, msg_out_valid=0, msg_output=0. A fresh empty-message request after release yields d41d8cd98f00b204e9800998ecf8427e.
REQ-027 Random blocks (30 runs, sampled 50 cycles after request) -> msg_output matches a software MD5 compression of IV plus the block.
